// File: rtl/ce_div_sample_pipe.sv
// Divided-rate sampler: programmable clock-enable tick, 50% divided clock_out,
// and a tick-sampled delay line, all in the clk_in domain.
module ce_div_sample_pipe #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 2,
  parameter int DIV_WIDTH   = 32,
  parameter int DEFAULT_DIV = 20000000
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 div_load,
  input  logic [DIV_WIDTH-1:0] div_val,
  input  logic                 flush,
  input  logic [WIDTH-1:0]     d,
  output logic                 tick,
  output logic                 clk_out,
  output logic [WIDTH-1:0]     q,
  output logic                 q_valid
);

  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [DIV_WIDTH-1:0] RESET_DIV =
    (DEFAULT_DIV == 0) ? DIV_WIDTH'(1) : DIV_WIDTH'(DEFAULT_DIV);

  logic [DIV_WIDTH-1:0] count_reg;
  logic [DIV_WIDTH-1:0] div_reg;
  logic [DIV_WIDTH-1:0] div_coerced;
  logic                 tick_reg;
  logic                 clk_out_reg;
  logic                 terminal;
  logic [FILL_W-1:0]    fill_reg;
  logic [FILL_W-1:0]    fill_next;
  logic                 q_valid_reg;
  logic                 shift_en;

  assign div_coerced = (div_val == '0) ? DIV_WIDTH'(1) : div_val;
  assign terminal    = (count_reg == div_reg - DIV_WIDTH'(1));

  // A load restarts the period and swallows any tick due in that cycle.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      count_reg   <= '0;
      div_reg     <= RESET_DIV;
      tick_reg    <= 1'b0;
      clk_out_reg <= 1'b0;
    end else if (div_load) begin
      div_reg   <= div_coerced;
      count_reg <= '0;
      tick_reg  <= 1'b0;
    end else if (run) begin
      if (terminal) begin
        count_reg   <= '0;
        tick_reg    <= 1'b1;
        clk_out_reg <= ~clk_out_reg;
      end else begin
        count_reg <= count_reg + DIV_WIDTH'(1);
        tick_reg  <= 1'b0;
      end
    end else begin
      tick_reg <= 1'b0;
    end
  end

  // The delay line freezes with the counter and never captures while flushing.
  assign shift_en = tick_reg && run && !flush;

  always_comb begin
    fill_next = fill_reg;
    if (flush)
      fill_next = '0;
    else if (shift_en && (fill_reg != FILL_W'(DEPTH)))
      fill_next = fill_reg + FILL_W'(1);
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      fill_reg    <= '0;
      q_valid_reg <= 1'b0;
    end else begin
      fill_reg    <= fill_next;
      q_valid_reg <= (fill_next == FILL_W'(DEPTH));
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] stage_reg;
      logic [WIDTH-1:0] stage_in;
      if (gi == 0) begin : g_head
        assign stage_in = d;
      end else begin : g_tail
        assign stage_in = g_stage[gi-1].stage_reg;
      end
      always_ff @(posedge clk_in) begin
        if (!rst || flush)
          stage_reg <= '0;
        else if (shift_en)
          stage_reg <= stage_in;
      end
    end
  endgenerate

  assign tick    = tick_reg;
  assign clk_out = clk_out_reg;
  assign q       = g_stage[DEPTH-1].stage_reg;
  assign q_valid = q_valid_reg;

endmodule

// File: tb/tb_ce_div_sample_pipe.sv
// Scoreboard bench for ce_div_sample_pipe: expected tick events are queued by
// the stimulus and matched by a monitor each time tick is seen high.
module tb_ce_div_sample_pipe;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        run;
  logic        div_load;
  logic [31:0] div_val;
  logic        flush;
  logic [7:0]  d;
  logic        tick;
  logic        clk_out;
  logic [7:0]  q;
  logic        q_valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int r;

  typedef struct {
    int         cyc;
    logic       clk_out;
    logic [7:0] q;
    logic       q_valid;
  } exp_t;
  exp_t exp_q[$];

  ce_div_sample_pipe #(
    .WIDTH(8), .DEPTH(3), .DIV_WIDTH(32), .DEFAULT_DIV(4)
  ) dut (
    .clk_in(clk_in), .rst(rst), .run(run), .div_load(div_load),
    .div_val(div_val), .flush(flush), .d(d), .tick(tick),
    .clk_out(clk_out), .q(q), .q_valid(q_valid)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input logic co, input logic [7:0] qd, input logic v);
    exp_t e;
    e.cyc = c; e.clk_out = co; e.q = qd; e.q_valid = v;
    exp_q.push_back(e);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // Monitor: every tick pulse is one transaction.
  always @(negedge clk_in) begin
    if (tick === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick at cycle %0d: got tick=1 expected none", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("tick at cycle %0d: clk_out=%0b q=%02h q_valid=%0b (exp cycle %0d %0b %02h %0b)",
                 cyc, clk_out, q, q_valid, e.cyc, e.clk_out, e.q, e.q_valid);
        chk("tick_cycle", cyc, e.cyc);
        chk("tick_clk_out", {31'd0, clk_out}, {31'd0, e.clk_out});
        chk("tick_q", {24'd0, q}, {24'd0, e.q});
        chk("tick_q_valid", {31'd0, q_valid}, {31'd0, e.q_valid});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; run = 1'b1; div_load = 1'b0; div_val = '0; flush = 1'b0; d = '0;
    goto(3);
    chk("reset_tick", {31'd0, tick}, 32'd0);
    chk("reset_clk_out", {31'd0, clk_out}, 32'd0);
    chk("reset_q", {24'd0, q}, 32'd0);
    chk("reset_q_valid", {31'd0, q_valid}, 32'd0);

    rst = 1'b1;
    r = cyc;
    // Expected tick events (cycle offset from release, clk_out, q, q_valid)
    push(r+4, 1, 8'h00, 0);  push(r+8, 0, 8'h00, 0);  push(r+12, 1, 8'h00, 0);
    push(r+16, 0, 8'h11, 1); push(r+20, 1, 8'h22, 1);
    push(r+34, 0, 8'h33, 1);
    push(r+40, 1, 8'h44, 1); push(r+42, 0, 8'h55, 1); push(r+44, 1, 8'h66, 1);
    push(r+46, 0, 8'h77, 1);
    push(r+48, 1, 8'h00, 0); push(r+50, 0, 8'h00, 0); push(r+52, 1, 8'h00, 0);
    push(r+54, 0, 8'hBB, 1);
    push(r+60, 1, 8'h00, 0); push(r+64, 0, 8'h00, 0); push(r+66, 1, 8'h00, 0);
    for (int i = 67; i <= 73; i++) push(r+i, (i % 2 == 0), 8'h5A, 1);

    // Pipeline fill: one new data value ahead of each tick
    goto(r+2);  d = 8'h11;
    goto(r+6);  d = 8'h22;
    goto(r+10); d = 8'h33;
    goto(r+13);
    chk("fill_q", {24'd0, q}, 32'h11);
    chk("fill_q_valid", {31'd0, q_valid}, 32'd1);
    goto(r+14); d = 8'h44;
    goto(r+18); d = 8'h55;

    // Freeze at count=2 for 10 cycles
    goto(r+22); d = 8'h66; run = 1'b0;
    goto(r+27);
    chk("freeze_clk_out", {31'd0, clk_out}, 32'd1);
    chk("freeze_q", {24'd0, q}, 32'h33);
    chk("freeze_tick", {31'd0, tick}, 32'd0);
    goto(r+32); run = 1'b1;

    // Reload divisor 2 on the terminal-count cycle
    goto(r+37); div_load = 1'b1; div_val = 32'd2;
    goto(r+38); div_load = 1'b0; d = 8'h77;
    goto(r+41); d = 8'h88;
    goto(r+43); d = 8'h99;

    // Flush coinciding with a tick
    goto(r+46); d = 8'hAA; flush = 1'b1;
    goto(r+47); flush = 1'b0; d = 8'hBB;
    chk("flush_q", {24'd0, q}, 32'd0);
    chk("flush_q_valid", {31'd0, q_valid}, 32'd0);
    chk("flush_clk_out", {31'd0, clk_out}, 32'd0);
    goto(r+49); d = 8'hCC;
    goto(r+51); d = 8'hDD;

    // Mid-operation reset while divisor 2 is active
    goto(r+55); rst = 1'b0;
    goto(r+56);
    chk("midrst_tick", {31'd0, tick}, 32'd0);
    chk("midrst_clk_out", {31'd0, clk_out}, 32'd0);
    chk("midrst_q", {24'd0, q}, 32'd0);
    chk("midrst_q_valid", {31'd0, q_valid}, 32'd0);
    rst = 1'b1; d = 8'h5A;

    // Divisor 0 coerced to 1: continuous ticks
    goto(r+64); div_load = 1'b1; div_val = 32'd0;
    goto(r+65); div_load = 1'b0;
    goto(r+73); run = 1'b0;
    goto(r+80);
    chk("pending_ticks", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ce_div_sample_pipe.md
Name: ce_div_sample_pipe

Overview:
Parametrised divided-rate sampler. It generates a single-cycle clock-enable tick from clk_in with a runtime-programmable divisor, plus a 50%-duty divided square wave. On each tick it samples a WIDTH-bit input into a DEPTH-stage delay line. All logic runs in the clk_in domain; no derived clock drives any flop. It sits between fast-clock logic and slow-rate consumers such as display refresh, debouncers and LED blink paths.

Parameters:
WIDTH, 8, data width of d / q
DEPTH, 2, number of tick-sampled pipeline stages (>=1)
DIV_WIDTH, 32, width of divisor and internal counter
DEFAULT_DIV, 20000000, divisor value loaded at reset

Ports:
clk_in  input  1  system clock; sole clock
rst  input  1  synchronous reset, active-low
run  input  1  1 = counter advances; 0 = freeze counter, ticks, clk_out and stages
div_load  input  1  strobe; load div_val into divisor register
div_val  input  DIV_WIDTH  new divisor (period in clk_in cycles)
flush  input  1  clear delay line and valid tracking
d  input  WIDTH  data sampled on tick
tick  output  1  one-cycle pulse, once per divisor period
clk_out  output  1  toggles on every tick; period = 2*divisor
q  output  WIDTH  last pipeline stage
q_valid  output  1  high once DEPTH ticks have filled the pipeline

Behaviour:
- Reset: one clock, one reset. rst is synchronous and active-low. It is sampled only on posedge clk_in while low. Effects: count=0, div_reg=DEFAULT_DIV (0 is coerced to 1), tick=0, clk_out=0, all stages=0, q=0, fill=0, q_valid=0. Reset overrides all other inputs.
- div_reg: registered, DIV_WIDTH bits. A value of 0 is coerced to 1 wherever it is loaded.
- Counter: while run=1 and div_load=0, count increments each cycle. When count==div_reg-1, count wraps to 0 and tick is registered high for the next cycle.
  - Ticks are exactly div_reg cycles apart.
  - div_reg=1 gives tick high continuously.
- tick is a registered output. It asserts the cycle after the terminal count is detected, and at most one cycle per period except when div_reg=1.
- clk_out: registered, toggles in the same cycle that tick asserts. High and low phases are each div_reg cycles.
- run=0: count, clk_out, stages and fill hold. tick is 0 the following cycle. Resuming continues from the held count, with no lost or extra tick.
- div_load=1 (any run value): div_reg<=coerced div_val, count<=0, and no tick is generated from that cycle.
  - If div_load coincides with the terminal count, the load wins and the tick is suppressed.
  - clk_out keeps its current level.
  - A new period begins on the cycle after the load.
- Delay line: in a cycle where tick is high, stage[0]<=d, stage[i]<=stage[i-1], and fill<=min(fill+1,DEPTH). q=stage[DEPTH-1], registered.
  - Latency from d sampled to q: DEPTH ticks.
  - q_valid=(fill==DEPTH), registered; it stays high until flush or reset.
- flush=1: stages<=0, fill<=0, q_valid<=0. The counter, tick and clk_out are unaffected. If flush coincides with tick, flush wins and d is not captured.
- Width rules: count compares at full DIV_WIDTH. div_val up to 2^DIV_WIDTH-1 is legal, and there is no overflow since count never exceeds div_reg-1. fill is ceil(log2(DEPTH+1)) bits and saturates.

Test Plan:
- DEFAULT_DIV overridden to 4, WIDTH=8, DEPTH=3. Release rst with run=1. Required: tick on cycles 4, 8, 12… after release; clk_out rises at 4, falls at 8; 1-cycle tick width.
- Pipeline fill: d=0x11 before tick 1, 0x22 before tick 2, 0x33 before tick 3. Required: q=0x11 and q_valid=1 the cycle after the 3rd tick; q=0x22 after the 4th tick.
- Freeze: run=0 for 10 cycles at count=2. Required: no tick, clk_out and q stable; after run=1 the next tick comes 2 cycles later.
- Reload: div_load with div_val=2 on the terminal-count cycle. Required: no tick that period, then ticks every 2 cycles. div_val=0 gives tick high continuously.
- Flush with tick: flush and tick in the same cycle. Required: q=0, q_valid=0, d not captured; q_valid returns after 3 further ticks; clk_out unaffected.
- Mid-operation reset: rst=0 for 1 cycle mid-period with div_reg=2 loaded. Required: all outputs 0 next cycle; divisor back to 4, first tick 4 cycles after release.
